// File: rtl/formal_stream_arbiter_rr_pick.sv
// Round-robin picker: the first requesting index at or after ptr, wrapping at n.
// Purely combinational; ptr is always below n, so a single subtract handles the wrap.
module rr_pick #(
  parameter int n  = 2,
  parameter int nw = 1
) (
  input  logic [n-1:0]  req,
  input  logic [nw-1:0] ptr,
  output logic          any,
  output logic [nw-1:0] idx
);

  function automatic logic [nw-1:0] wrap_add(input logic [nw-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= n) sum = sum - n;
    return sum[nw-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = n - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr, k)]) idx = wrap_add(ptr, k);
    end
  end

endmodule

// File: rtl/formal_stream_arbiter.sv
// Packet-locked round-robin arbiter merging n valid/ready streams into one
// registered output; the grant is held from a packet's first beat to its last.
module formal_stream_arbiter #(
  parameter int n  = 2,
  parameter int dw = 32,
  localparam int nw = (n > 1) ? $clog2(n) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [n-1:0]    s_valid,
  output logic [n-1:0]    s_ready,
  input  logic [n*dw-1:0] s_data,
  input  logic [n-1:0]    s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [dw-1:0]   m_data,
  output logic            m_last,
  output logic [nw-1:0]   m_sel
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_BUSY = 1'b1;
  localparam logic [nw-1:0] LAST_IDX = nw'(n - 1);

  logic            state_q, state_d;
  logic [nw-1:0]   rr_ptr_q, rr_ptr_d;
  logic [nw-1:0]   grant_q, grant_d;
  logic            m_valid_q, m_valid_d;
  logic [dw-1:0]   m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic [nw-1:0]   m_sel_q, m_sel_d;

  logic            pick_any;
  logic [nw-1:0]   pick_idx;
  logic            accept;
  logic [dw-1:0]   granted_data;

  rr_pick #(.n(n), .nw(nw)) u_pick (
    .req (s_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign granted_data = s_data[int'(grant_q)*dw +: dw];
  assign accept       = (state_q == STATE_BUSY) && s_valid[grant_q] && s_ready[grant_q];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= STATE_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_sel_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_sel_q   <= m_sel_d;
    end
  end

  // Wrap is an explicit compare so non-power-of-two n never yields an out-of-range pointer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      STATE_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = STATE_BUSY;
        end
      end
      default: begin
        if (accept && s_last[grant_q]) begin
          state_d  = STATE_IDLE;
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + nw'(1);
        end
      end
    endcase
  end

  always_comb begin
    s_ready = '0;
    if (state_q == STATE_BUSY) s_ready[grant_q] = !m_valid_q || m_ready;
  end

  // Load and drain may coincide, giving one beat per cycle inside a packet.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_sel_d   = m_sel_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = granted_data;
      m_last_d  = s_last[grant_q];
      m_sel_d   = grant_q;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_sel   = m_sel_q;

endmodule

// File: tb/tb_formal_stream_arbiter.sv
// Scoreboard bench for formal_stream_arbiter (n=3): expected beats follow strict
// round-robin packet order whenever every requester keeps a packet pending.
module tb_formal_stream_arbiter;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int NW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [NW-1:0] sel;
  } beat_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_last;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic [NW-1:0]   m_sel;

  always #5 clk = ~clk;

  formal_stream_arbiter #(.n(N), .dw(DW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_sel   (m_sel)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  beat_t        src_q[N][$];
  beat_t        exp_q[$];
  logic [N-1:0] acc_mask = '0;
  logic [N-1:0] in_pkt;
  int           gap_cnt[N];
  bit           gaps_en = 0;
  bit           rand_ready = 0;
  bit           fixed_ready = 0;
  int           model_rr = 0;
  int           first_mv_cyc = -1;
  int           last_pop_cyc = -1;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Sink-side monitor: sampled mid-cycle, after inputs and s_ready have settled.
  bit            prev_ok = 0;
  bit            prev_stall = 0;
  bit            prev_last_acc = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [NW-1:0] prev_sel;
  beat_t         e;

  always @(negedge clk) begin
    if (resetn) begin
      acc_mask = s_valid & s_ready;
      check("ready_onehot", $countones(s_ready) <= 1, 64'(s_ready), 64'(0));
      if (m_valid && !m_ready) check("ready_in_stall", s_ready == '0, 64'(s_ready), 64'(0));
      if (prev_ok && prev_stall)
        check("stall_hold", {m_valid, m_data, m_last, m_sel} == {1'b1, prev_data, prev_last, prev_sel},
              64'({m_valid, m_data, m_last, m_sel}), 64'({1'b1, prev_data, prev_last, prev_sel}));
      if (prev_ok && prev_last_acc) check("idle_bubble", s_ready == '0, 64'(s_ready), 64'(0));
      if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b0, 64'({m_data, m_last, m_sel}), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_data, m_last, m_sel} == {e.data, e.last, e.sel},
                64'({m_data, m_last, m_sel}), 64'({e.data, e.last, e.sel}));
          last_pop_cyc = cyc;
          $display("cycle %0d beat sel=%0d data=0x%04h last=%0b", cyc, m_sel, m_data, m_last);
        end
      end
      prev_stall    = m_valid && !m_ready;
      prev_data     = m_data;
      prev_last     = m_last;
      prev_sel      = m_sel;
      prev_last_acc = |(acc_mask & s_last);
      prev_ok       = 1;
    end else begin
      acc_mask = '0;
      prev_ok  = 0;
    end
  end

  function automatic bit src_pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1;
    return 0;
  endfunction

  // One clock: retire beats accepted at this edge, then present the next ones.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] && src_q[i].size() > 0) begin
        in_pkt[i] = !src_q[i][0].last;
        void'(src_q[i].pop_front());
      end
      if (gap_cnt[i] > 0) gap_cnt[i]--;
      else if (gaps_en && in_pkt[i] && $urandom_range(0, 5) == 0) gap_cnt[i] = $urandom_range(1, 5);
      s_valid[i] = (src_q[i].size() > 0) && (gap_cnt[i] == 0);
      if (src_q[i].size() > 0) begin
        s_data[i*DW +: DW] = src_q[i][0].data;
        s_last[i]          = src_q[i][0].last;
      end
    end
    m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  endtask

  task automatic push_pkt(input int i, input int len, input bit rnd, input logic [DW-1:0] base, input bit to_exp);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = rnd ? DW'($urandom) : base + DW'(k);
      b.last = (k == len - 1);
      b.sel  = NW'(i);
      src_q[i].push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
  endtask

  task automatic run_until_drained(input int budget, input string name);
    int k = 0;
    while ((exp_q.size() > 0 || src_pending()) && k < budget) begin
      step();
      k++;
    end
    check(name, exp_q.size() == 0 && !src_pending(), 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int t0;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    m_ready = 1'b0;
    in_pkt  = '0;
    for (int i = 0; i < N; i++) gap_cnt[i] = 0;

    repeat (3) step();
    check("rst_m_valid", m_valid == 1'b0, 64'(m_valid), 64'(0));
    check("rst_m_data", m_data == '0, 64'(m_data), 64'(0));
    check("rst_m_last", m_last == 1'b0, 64'(m_last), 64'(0));
    check("rst_m_sel", m_sel == '0, 64'(m_sel), 64'(0));
    check("rst_s_ready", s_ready == '0, 64'(s_ready), 64'(0));

    // Single packet from requester 0 with the sink always ready.
    resetn      = 1'b1;
    fixed_ready = 1'b1;
    push_pkt(0, 3, 1'b0, 16'h00A0, 1'b1);
    first_mv_cyc = -1;
    step();
    t0 = cyc;
    run_until_drained(40, "single_drain");
    check("single_latency", first_mv_cyc == t0 + 2, 64'(first_mv_cyc), 64'(t0 + 2));
    check("single_back_to_back", last_pop_cyc == t0 + 4, 64'(last_pop_cyc), 64'(t0 + 4));
    model_rr = 1;

    // Saturated random traffic: gaps inside packets, random backpressure.
    gaps_en    = 1;
    rand_ready = 1;
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < N; k++)
        push_pkt((model_rr + k) % N, $urandom_range(1, 4), 1'b1, '0, 1'b1);
    run_until_drained(3000, "random_drain");

    // Reset while requester 2 is mid-packet with an output beat held.
    gaps_en     = 0;
    rand_ready  = 0;
    fixed_ready = 0;
    push_pkt(2, 4, 1'b1, '0, 1'b0);
    for (int k = 0; k < 20 && src_q[2].size() == 4; k++) step();
    check("mid_first_accept", src_q[2].size() == 3, 64'(src_q[2].size()), 64'(3));
    check("mid_beat_held", m_valid == 1'b1, 64'(m_valid), 64'(1));
    resetn = 1'b0;
    step();
    check("mid_rst_m_valid", m_valid == 1'b0, 64'(m_valid), 64'(0));
    check("mid_rst_m_data", m_data == '0, 64'(m_data), 64'(0));
    check("mid_rst_s_ready", s_ready == '0, 64'(s_ready), 64'(0));
    src_q[2].delete();
    in_pkt  = '0;
    s_valid = '0;
    resetn  = 1'b1;
    model_rr    = 0;
    fixed_ready = 1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        push_pkt(i, 1, 1'b1, '0, 1'b1);
    run_until_drained(200, "after_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
